// File: rtl/udp_writer.sv
// +------------------------------------------------------------------------+
// | udp_writer: frames a CAPACITY-byte snapshot as MAGIC|seq|payload|csum  |
// | and hands it out one byte per read strobe. Revision: 1.0               |
// +------------------------------------------------------------------------+
`default_nettype none

module udp_writer #(
  parameter int          CAPACITY = 6,
  parameter logic [15:0] MAGIC    = 16'hA55A,
  parameter int          TIMEOUT  = 1_250_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  send,
  input  logic [CAPACITY*8-1:0] i_data,
  output logic                  trig,
  input  logic                  read_en,
  output logic [7:0]            o_data,
  output logic [15:0]           data_len,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int c_len   = CAPACITY + 4;
  localparam int c_idx_w = $clog2(c_len);
  localparam int c_cnt_w = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                r_state;
  logic [CAPACITY*8-1:0] r_snap;
  logic [7:0]            r_csum;
  logic [7:0]            r_seq;
  logic                  r_pending;
  logic [c_idx_w-1:0]    r_idx;
  logic [c_cnt_w-1:0]    r_cnt;

  logic [7:0] w_sum;
  logic [7:0] w_byte;

  assign data_len = 16'(c_len);

  // Checksum covers seq and the live payload; it is latched together with the snapshot.
  always_comb begin
    w_sum = r_seq;
    for (int b = 0; b < CAPACITY; b++) begin
      w_sum = w_sum + i_data[b*8 +: 8];
    end
  end

  always_comb begin
    w_byte = r_csum;
    if (r_idx == c_idx_w'(0)) begin
      w_byte = MAGIC[15:8];
    end else if (r_idx == c_idx_w'(1)) begin
      w_byte = MAGIC[7:0];
    end else if (r_idx == c_idx_w'(2)) begin
      w_byte = r_seq;
    end else begin
      for (int b = 0; b < CAPACITY; b++) begin
        if (r_idx == c_idx_w'(b + 3)) begin
          w_byte = r_snap[(CAPACITY-1-b)*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_snap    <= '0;
      r_csum    <= 8'h00;
      r_seq     <= 8'h00;
      r_pending <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
      trig      <= 1'b0;
      o_data    <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      trig  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      if (send && r_state != S_IDLE) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (read_en) error <= 1'b1;
          if (send || r_pending) begin
            r_state   <= S_ARM;
            r_pending <= 1'b0;
            trig      <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_ARM: begin
          if (read_en) error <= 1'b1;
          r_snap  <= i_data;
          r_csum  <= w_sum;
          r_idx   <= '0;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // The error pulse occupies the cycle where the count sits at TIMEOUT; busy drops after it.
          if (r_cnt == c_cnt_w'(TIMEOUT)) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else if (read_en) begin
            o_data  <= w_byte;
            r_idx   <= r_idx + 1'b1;
            r_state <= S_SEND;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_cnt_w'(TIMEOUT - 1)) error <= 1'b1;
          end
        end
        S_SEND: begin
          if (read_en) begin
            o_data <= w_byte;
            r_idx  <= r_idx + 1'b1;
            if (r_idx == c_idx_w'(c_len - 1)) begin
              r_state <= S_DONE;
              done    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (read_en) error <= 1'b1;
          r_seq   <= r_seq + 8'h01;
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/udp_writer.md
# udp_writer

Frame serializer for the UDP transmit path: snapshots a CAPACITY-byte parallel word, frames it with a magic header, sequence number and checksum, and hands bytes to the UDP packet engine one per read strobe. It is the transmit-side counterpart of the UDP byte-stream reader that fills the box-coordinate buffer. It runs in the RGMII clock domain between a status or result producer and the UDP packet engine's trig, tx_read_en and tx_data ports.

## Interface
- CAPACITY, 6: payload bytes per frame (1..250).
- MAGIC, 16'hA55A: header, sent MSB first.
- TIMEOUT, 1_250_000: clk cycles allowed between trig and the first read_en.
- clk  in  1  RGMII-domain clock.
- rstn  in  1  synchronous, active-low reset.
- send  in  1  request to transmit; level-sampled each cycle.
- i_data  in  CAPACITY*8  payload; byte 0 = i_data[CAPACITY*8-1 -: 8].
- trig  out  1  one-cycle start pulse to the UDP packet engine.
- read_en  in  1  byte consume strobe from the UDP packet engine.
- o_data  out  8  frame byte.
- data_len  out  16  constant CAPACITY+4.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse, frame fully read.
- error  out  1  one-cycle pulse on timeout or stray read_en.

## Operation
- Frame, LEN = CAPACITY+4 bytes, in this order:
  - MAGIC[15:8], MAGIC[7:0];
  - seq;
  - payload bytes 0..CAPACITY-1;
  - csum = (seq + all payload bytes) mod 256. The header is excluded from csum.
- seq: 8-bit, reset 0, increments (wraps 255→0) only on done. A timed-out frame does not increment it.
- States and transitions:
  - IDLE → ARM when send=1 or pending=1.
  - ARM: latch i_data and compute csum; trig=1 for this cycle only → WAIT.
  - WAIT: timeout counter counts up from 0. First read_en → SEND (byte 0 issued). Counter reaches TIMEOUT → error pulse, → IDLE, pending unchanged.
  - SEND: each read_en issues the next byte. Read of byte LEN-1 → DONE.
  - DONE: done=1 → IDLE.
- busy=1 in ARM, WAIT, SEND and DONE.
- send while busy sets pending, a single bit. Further sends while pending is already set are merged. pending clears on entry to ARM. The snapshot is taken at ARM, never at request time.
- read_en in IDLE, ARM or DONE is ignored, and error pulses on the following cycle. o_data is unchanged.
- Byte index counter width is $clog2(LEN). Payload byte selection uses the latched snapshot only; i_data changes after ARM have no effect.

## Timing
- Reset values: trig=0, o_data=8'h00, busy=0, done=0, error=0, seq=0, pending=0, state IDLE. Reset mid-frame aborts with no done and no error.
- data_len is constant: CAPACITY+4.
- send high at edge n (IDLE) → trig=1 and busy=1 in cycle n+1; WAIT from n+2.
- FIFO-style read: read_en high at cycle k → the corresponding byte is on o_data at k+1 and held until the next consumed read_en.
- Back-to-back read_en gives one byte per cycle. Gaps of any length are allowed.
- Last read_en at cycle m → last byte and done=1 at m+1; busy=0 from m+2. With pending set, trig fires at m+3.
- Timeout: with no read_en, error=1 exactly TIMEOUT+1 cycles after the trig cycle; busy=0 the cycle after the error.
- o_data keeps its last value across frames until the next frame's first read.

## Test plan
- Basic frame:
  - Stimulus: CAPACITY=6, i_data=48'h010203040506, one send pulse, continuous read_en×10 starting 3 cycles after trig.
  - Required: trig exactly one cycle; o_data = A5 5A 00 01 02 03 04 05 06 15; done once; busy drop at m+2.
- Sequence and checksum wrap:
  - Stimulus: 256 consecutive frames with i_data=48'hFFFFFFFFFFFF.
  - Required: seq runs 00..FF then 00. Frame seq=0x03 has csum = (3+6×0xFF) mod 256 = 0xFD.
- Gapped reads and snapshot:
  - Stimulus: read_en every 3rd cycle; i_data changed after trig.
  - Required: bytes equal the pre-trig snapshot; o_data stable between strobes.
- Pending merge:
  - Stimulus: send held high for 20 cycles during a frame.
  - Required: exactly one extra frame follows, with trig at m+3.
- Timeout:
  - Stimulus: TIMEOUT=50, send with no read_en.
  - Required: error at trig+51; busy=0 after; seq unchanged. A later good frame reuses the same seq.
- Stray read and reset:
  - Stimulus: read_en in IDLE; then rstn=0 during SEND byte 4.
  - Required: the stray read gives error one cycle later with o_data unchanged. The reset returns all outputs to reset values with no done.
